// File: rtl/regfile_scoreboard.sv
// Integer register file: 2 async read ports, 1 sync write port, busy scoreboard.
// Ports: clk, rst_n, r1/r2 read ports (+busy), rd write port, issue port, busy_count.
// Optional: define REGFILE_BYPASS_EN for same-cycle write-through forwarding.
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] r1_address,
  input  logic [ADDR_WIDTH-1:0] r2_address,
  output logic [DATA_WIDTH-1:0] r1_out,
  output logic [DATA_WIDTH-1:0] r2_out,
  output logic                  r1_busy,
  output logic                  r2_busy,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  input  logic [DATA_WIDTH-1:0] rd_data_in,
  input  logic                  rd_write_enb,
  input  logic                  issue_enb,
  input  logic [ADDR_WIDTH-1:0] issue_address,
  output logic [ADDR_WIDTH:0]   busy_count
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_nxt;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  wr_ok;
  logic                  iss_ok;
  logic                  z1;
  logic                  z2;

  // x0 is hardwired: its writes and issues are dropped
  assign wr_ok  = rd_write_enb
                & ~((ZERO_REG != 0) & (rd_address == '0));
  assign iss_ok = issue_enb
                & ~((ZERO_REG != 0) & (issue_address == '0));

  // Set beats clear: a fresh producer supersedes the completing one
  always_comb begin
    busy_nxt  = busy;
    count_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (iss_ok && issue_address == ADDR_WIDTH'(i))
        busy_nxt[i] = 1'b1;
      else if (wr_ok && rd_address == ADDR_WIDTH'(i))
        busy_nxt[i] = 1'b0;
      count_nxt = count_nxt + (ADDR_WIDTH+1)'(busy_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= count_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wr_ok) begin
      regs[rd_address] <= rd_data_in;
    end
  end

  assign z1 = (ZERO_REG != 0) & (r1_address == '0);
  assign z2 = (ZERO_REG != 0) & (r2_address == '0);

`ifdef REGFILE_BYPASS_EN
  logic fwd1;
  logic fwd2;

  // rst_n gate keeps reads at 0 while reset is held
  assign fwd1 = rst_n & wr_ok & (rd_address == r1_address);
  assign fwd2 = rst_n & wr_ok & (rd_address == r2_address);

  always_comb begin
    r1_out  = z1 ? '0 : regs[r1_address];
    r1_busy = ~z1 & busy[r1_address];
    r2_out  = z2 ? '0 : regs[r2_address];
    r2_busy = ~z2 & busy[r2_address];
    if (fwd1) begin
      r1_out  = rd_data_in;
      r1_busy = iss_ok & (issue_address == r1_address);
    end
    if (fwd2) begin
      r2_out  = rd_data_in;
      r2_busy = iss_ok & (issue_address == r2_address);
    end
  end
`else
  always_comb begin
    r1_out  = z1 ? '0 : regs[r1_address];
    r1_busy = ~z1 & busy[r1_address];
    r2_out  = z2 ? '0 : regs[r2_address];
    r2_busy = ~z2 & busy[r2_address];
  end
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard.
// Expected values are hand-computed constants.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [4:0]  r1_address;
  logic [4:0]  r2_address;
  logic [31:0] r1_out;
  logic [31:0] r2_out;
  logic        r1_busy;
  logic        r2_busy;
  logic [4:0]  rd_address;
  logic [31:0] rd_data_in;
  logic        rd_write_enb;
  logic        issue_enb;
  logic [4:0]  issue_address;
  logic [5:0]  busy_count;

  int checks;
  int errors;

  regfile_scoreboard dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .r1_address    (r1_address),
    .r2_address    (r2_address),
    .r1_out        (r1_out),
    .r2_out        (r2_out),
    .r1_busy       (r1_busy),
    .r2_busy       (r2_busy),
    .rd_address    (rd_address),
    .rd_data_in    (rd_data_in),
    .rd_write_enb  (rd_write_enb),
    .issue_enb     (issue_enb),
    .issue_address (issue_address),
    .busy_count    (busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b1;
    r1_address    = 5'd5;
    r2_address    = 5'd31;
    rd_address    = '0;
    rd_data_in    = '0;
    rd_write_enb  = 1'b0;
    issue_enb     = 1'b0;
    issue_address = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_r1_out", 64'(r1_out), 64'h0);
    chk("rst_r2_out", 64'(r2_out), 64'h0);
    chk("rst_r1_busy", 64'(r1_busy), 64'h0);
    chk("rst_r2_busy", 64'(r2_busy), 64'h0);
    chk("rst_count", 64'(busy_count), 64'h0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;

    // write x5 and read back
    rd_address   = 5'd5;
    rd_data_in   = 32'hDEADBEEF;
    rd_write_enb = 1'b1;
    tick();
    rd_write_enb = 1'b0;
    #1;
    chk("wr_x5", 64'(r1_out), 64'hDEADBEEF);
    chk("wr_x5_busy", 64'(r1_busy), 64'h0);

    // x0 ignores writes
    rd_address   = 5'd0;
    rd_data_in   = 32'hFFFFFFFF;
    rd_write_enb = 1'b1;
    r2_address   = 5'd0;
    tick();
    rd_write_enb = 1'b0;
    #1;
    chk("wr_x0", 64'(r2_out), 64'h0);

    // both ports on the same index
    r2_address = 5'd5;
    #1;
    chk("dual_r1", 64'(r1_out), 64'hDEADBEEF);
    chk("dual_r2", 64'(r2_out), 64'hDEADBEEF);

    // issue x7 then writeback
    r1_address    = 5'd7;
    issue_address = 5'd7;
    issue_enb     = 1'b1;
    tick();
    issue_enb = 1'b0;
    #1;
    chk("iss_x7_busy", 64'(r1_busy), 64'h1);
    chk("iss_x7_cnt", 64'(busy_count), 64'h1);
    rd_address   = 5'd7;
    rd_data_in   = 32'h12345678;
    rd_write_enb = 1'b1;
    tick();
    rd_write_enb = 1'b0;
    #1;
    chk("wb_x7_busy", 64'(r1_busy), 64'h0);
    chk("wb_x7_cnt", 64'(busy_count), 64'h0);
    chk("wb_x7_data", 64'(r1_out), 64'h12345678);

    // issue to x0 is ignored
    r2_address    = 5'd0;
    issue_address = 5'd0;
    issue_enb     = 1'b1;
    tick();
    issue_enb = 1'b0;
    #1;
    chk("iss_x0_busy", 64'(r2_busy), 64'h0);
    chk("iss_x0_cnt", 64'(busy_count), 64'h0);

    // x9 busy, then simultaneous issue+writeback
    r1_address    = 5'd9;
    issue_address = 5'd9;
    issue_enb     = 1'b1;
    tick();
    #1;
    chk("x9_cnt1", 64'(busy_count), 64'h1);
    rd_address   = 5'd9;
    rd_data_in   = 32'hA5A5A5A5;
    rd_write_enb = 1'b1;
    tick();
    issue_enb    = 1'b0;
    rd_write_enb = 1'b0;
    #1;
    chk("sim_x9_busy", 64'(r1_busy), 64'h1);
    chk("sim_x9_data", 64'(r1_out), 64'hA5A5A5A5);
    chk("sim_x9_cnt", 64'(busy_count), 64'h1);
    rd_data_in   = 32'h0000_0099;
    rd_write_enb = 1'b1;
    tick();
    rd_write_enb = 1'b0;
    #1;
    chk("clr_x9_cnt", 64'(busy_count), 64'h0);
    chk("clr_x9_data", 64'(r1_out), 64'h99);

    // same-cycle write to x3 while reading it
    r1_address   = 5'd3;
    rd_address   = 5'd3;
    rd_data_in   = 32'hCAFEF00D;
    rd_write_enb = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_x3_data", 64'(r1_out), 64'hCAFEF00D);
`else
    chk("byp_x3_data", 64'(r1_out), 64'h0);
`endif
    chk("byp_x3_busy", 64'(r1_busy), 64'h0);
    issue_address = 5'd3;
    issue_enb     = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_x3_iss", 64'(r1_busy), 64'h1);
`else
    chk("byp_x3_iss", 64'(r1_busy), 64'h0);
`endif
    tick();
    issue_enb    = 1'b0;
    rd_write_enb = 1'b0;
    #1;
    chk("post_x3_data", 64'(r1_out), 64'hCAFEF00D);
    chk("post_x3_busy", 64'(r1_busy), 64'h1);
    chk("post_x3_cnt", 64'(busy_count), 64'h1);
    rd_write_enb = 1'b1;
    tick();
    rd_write_enb = 1'b0;
    #1;
    chk("clr_x3_cnt", 64'(busy_count), 64'h0);

    // x4..x6 busy, then async reset between edges
    issue_enb = 1'b1;
    for (int i = 4; i <= 6; i++) begin
      issue_address = 5'(i);
      tick();
    end
    #1;
    chk("iss3_cnt", 64'(busy_count), 64'h3);
    issue_address = 5'd8;
    r1_address    = 5'd4;
    r2_address    = 5'd5;
    #1;
    chk("iss3_r1_busy", 64'(r1_busy), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", 64'(busy_count), 64'h0);
    chk("arst_r1_busy", 64'(r1_busy), 64'h0);
    chk("arst_r2_out", 64'(r2_out), 64'h0);
    tick();
    chk("arst_hold_cnt", 64'(busy_count), 64'h0);
    @(negedge clk);
    issue_enb = 1'b0;
    rst_n     = 1'b1;
    tick();
    chk("after_rst_cnt", 64'(busy_count), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
